// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type, frame constants and parity helper for the PS/2 receiver
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

    localparam int PS2_DATA_BITS  = 8;
    localparam int PS2_FRAME_BITS = 11;

    // Parity bit that makes the 8 data bits plus parity contain an odd number of ones
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: first-word fall-through byte FIFO; push and pop in the same cycle both succeed even when full
module ps2_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            rd_ptr <= rd_ptr + AW'(pop_ok);
            level  <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with clock deglitching, frame checking and byte FIFO
// Optional PS2_RX_INHIBIT_EN adds ps2_clk_oe, which holds the PS/2 clock low while the FIFO is nearly full.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_data_i,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PS2_RX_INHIBIT_EN
    , output logic                        ps2_clk_oe
`endif
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic                     clk_s1, clk_s2, dat_s1, dat_s2;
    logic                     filt, filt_q;
    logic [FW-1:0]            fcnt;
    logic                     fall, fall_g;
    ps2_rx_state_t            state, state_n;
    logic [2:0]               bcnt, bcnt_n;
    logic [PS2_DATA_BITS-1:0] shreg, shreg_n;
    logic                     par, par_n;
    logic [TW-1:0]            tcnt;
    logic                     timeout;
    logic                     push, perr_n, ferr_n;
    logic                     full, empty;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            {clk_s1, clk_s2, dat_s1, dat_s2} <= '1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data_i;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive samples at the new level
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            filt   <= 1'b1;
            filt_q <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_q <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall = filt_q & ~filt;

`ifdef PS2_RX_INHIBIT_EN
    // Inhibit only starts between frames but releases as soon as the FIFO drains below the threshold
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) ps2_clk_oe <= 1'b0;
        else         ps2_clk_oe <= (fifo_level >= LW'(FIFO_DEPTH - 1)) && (ps2_clk_oe || state == IDLE);
    end
    assign fall_g = fall & ~ps2_clk_oe;
`else
    assign fall_g = fall;
`endif

    // Idle-time counter; a partial frame is abandoned when it saturates
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                           tcnt <= '0;
        else if (fall_g || state == IDLE)      tcnt <= '0;
        else if (tcnt != TW'(TIMEOUT_CYCLES - 1)) tcnt <= tcnt + TW'(1);
    end

    assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Frame state, shift register and registered status pulses
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= IDLE;
            bcnt       <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bcnt       <= bcnt_n;
            shreg      <= shreg_n;
            par        <= par_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            overflow   <= push && full && !rx_ready;
        end
    end

    // Frame decoder: advances on filtered falls, otherwise only the timeout can move it
    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        par_n   = par;
        push    = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        if (fall_g) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n = DATA;
                        bcnt_n  = '0;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                DATA: begin
                    shreg_n = {dat_s2, shreg[PS2_DATA_BITS-1:1]};
                    bcnt_n  = bcnt + 3'd1;
                    if (bcnt == 3'(PS2_DATA_BITS - 1)) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (!dat_s2)                     ferr_n = 1'b1;
                    else if (par != odd_parity(shreg)) perr_n = 1'b1;
                    else                             push   = 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end else if (timeout) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end

    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (push),
        .din    (shreg),
        .pop    (rx_ready),
        .dout   (rx_data),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );

    assign rx_valid = ~empty;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed PS/2 frame stimulus with a scoreboard of expected bytes; define PS2_RX_INHIBIT_EN to cover ps2_clk_oe
module tb_ps2_rx;

    localparam int HP  = 40;
    localparam int TO  = 1000;
    localparam int FL  = 4;
    localparam int LAT = 2 + FL + 1;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overflow;
    logic [2:0] fifo_level;
`ifdef PS2_RX_INHIBIT_EN
    logic       ps2_clk_oe;
`endif

    int         compared = 0;
    int         mism = 0;
    int         perr_cnt = 0;
    int         ferr_cnt = 0;
    int         ovf_cnt = 0;
    int         p0, f0, o0;
    logic [8:0] exp_q[$];
    logic [8:0] e_mon;

    ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_dat),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_level (fifo_level)
`ifdef PS2_RX_INHIBIT_EN
        , .ps2_clk_oe (ps2_clk_oe)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic s);
        return {s, p, b, 1'b0};
    endfunction

    function automatic logic op(input logic [7:0] b);
        logic ones_odd;
        ones_odd = ^b;
        return ones_odd ? 1'b0 : 1'b1;
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n, input int g);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            if (i == g) begin
                repeat (HP / 2) tick();
                ps2_clk = 1'b0;
                repeat (2) tick();
                ps2_clk = 1'b1;
                repeat (HP / 2 - 2) tick();
            end else begin
                repeat (HP) tick();
            end
            ps2_clk = 1'b0;
            repeat (HP) tick();
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic s);
        send_bits(mk(b, p, s), 11, -1);
        ps2_dat = 1'b1;
        repeat (HP) tick();
    endtask

    // Scoreboard pop and pulse counting, sampled just after the falling edge
    always @(negedge clk) begin
        #1;
        if (resetb) begin
            if (rx_valid && rx_ready) begin
                if (exp_q.size() != 0) e_mon = exp_q.pop_front();
                else                   e_mon = 9'h100;
                chk("rx_data", {24'd0, rx_data}, {23'd0, e_mon});
            end
            perr_cnt += int'(parity_err);
            ferr_cnt += int'(frame_err);
            ovf_cnt  += int'(overflow);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_pulses", {parity_err, frame_err, overflow}, 0);
`ifdef PS2_RX_INHIBIT_EN
        chk("rst_oe", ps2_clk_oe, 0);
`endif
        resetb = 1'b1;
        repeat (5) tick();

        exp_q.push_back(9'h1C);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 10, -1);
        ps2_dat = 1'b1;
        repeat (HP) tick();
        ps2_clk = 1'b0;
        repeat (LAT - 1) tick();
        chk("t1_early", rx_valid, 0);
        tick();
        chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'h1C);
        tick();
        chk("t1_one_cycle", rx_valid, 0);
        repeat (HP - LAT - 1) tick();
        ps2_clk = 1'b1;
        repeat (HP) tick();
        chk("t1_perr", perr_cnt, 0);
        chk("t1_ferr", ferr_cnt, 0);

        rx_ready = 1'b0;
        exp_q.push_back(9'hF0);
        exp_q.push_back(9'h1C);
        send(8'hF0, 1'b1, 1'b1);
        send(8'h1C, 1'b0, 1'b1);
        chk("t2_level", fifo_level, 2);
        chk("t2_head", rx_data, 8'hF0);
        rx_ready = 1'b1;
        tick();
        chk("t2_second", rx_data, 8'h1C);
        tick();
        chk("t2_drained", rx_valid, 0);

        p0 = perr_cnt;
        f0 = ferr_cnt;
        send(8'hF0, 1'b0, 1'b1);
        chk("t3_perr", perr_cnt, p0 + 1);
        chk("t3_perr_nofe", ferr_cnt, f0);
        chk("t3_perr_level", fifo_level, 0);
        send(8'h1C, 1'b1, 1'b0);
        chk("t3_ferr", ferr_cnt, f0 + 1);
        chk("t3_ferr_nope", perr_cnt, p0 + 1);
        chk("t3_ferr_level", fifo_level, 0);

        f0 = ferr_cnt;
        send_bits(mk(8'hA5, 1'b0, 1'b1), 6, -1);
        ps2_dat = 1'b1;
        repeat (LAT + TO - 1 - HP) tick();
        chk("t4_early", frame_err, 0);
        tick();
        chk("t4_timeout", frame_err, 1);
        tick();
        chk("t4_pulse", frame_err, 0);
        chk("t4_ferr_cnt", ferr_cnt, f0 + 1);
        exp_q.push_back(9'h55);
        send(8'h55, op(8'h55), 1'b1);
        repeat (5) tick();
        chk("t4_recover_sb", exp_q.size(), 0);
        chk("t4_recover_ferr", ferr_cnt, f0 + 1);

        f0 = ferr_cnt;
        exp_q.push_back(9'h1C);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 4);
        ps2_dat = 1'b1;
        repeat (HP) tick();
        chk("t5_glitch_sb", exp_q.size(), 0);
        chk("t5_glitch_ferr", ferr_cnt, f0);
        rx_ready = 1'b0;
        send(8'h33, op(8'h33), 1'b1);
        chk("t5_pre_level", fifo_level, 1);
        send_bits(mk(8'h77, op(8'h77), 1'b1), 4, -1);
        resetb = 1'b0;
        #1;
        chk("t5_rst_valid", rx_valid, 0);
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_data", rx_data, 0);
        chk("t5_rst_pulses", {parity_err, frame_err, overflow}, 0);
        tick();
        ps2_dat = 1'b1;
        resetb = 1'b1;
        repeat (5) tick();

        o0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) begin
`ifdef PS2_RX_INHIBIT_EN
            if (i <= 3) exp_q.push_back(9'(i));
`else
            if (i <= 4) exp_q.push_back(9'(i));
`endif
            send(8'(i), op(8'(i)), 1'b1);
`ifdef PS2_RX_INHIBIT_EN
            if (i == 3) chk("t6_oe", ps2_clk_oe, 1);
`else
            if (i == 4) chk("t6_no_ovf_yet", ovf_cnt, o0);
`endif
        end
`ifdef PS2_RX_INHIBIT_EN
        chk("t6_level", fifo_level, 3);
        chk("t6_ovf", ovf_cnt, o0);
`else
        chk("t6_level", fifo_level, 4);
        chk("t6_ovf", ovf_cnt, o0 + 1);
`endif
        rx_ready = 1'b1;
        repeat (8) tick();
        chk("t6_drain_level", fifo_level, 0);
        chk("t6_drain_sb", exp_q.size(), 0);
`ifdef PS2_RX_INHIBIT_EN
        chk("t6_oe_release", ps2_clk_oe, 0);
`endif

        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
